// File: rtl/trace_drain.sv
// trace_drain: reader side of the trace circular buffer.
//
// Walks the ring from the oldest valid entry (first_i) to the newest valid entry
// (last_i, inclusive), wrapping modulo 2**IdxWidth. For every entry it fetches
// NumFields words over a single-port request/grant/rvalid memory interface and
// presents the assembled record on a valid/ready stream.
//
// Word address of field f of entry idx is f*2**IdxWidth + idx.
//
// Optional build macro: TRACE_DRAIN_CLEAR_EN
//   Defined   : every read is followed by a write of 0 to the same address
//               (clear-on-read); the write response rvalid is consumed and ignored.
//   Undefined : read-only; mem_we_o is constantly 0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, abort_i        start pulse (idle only), abort request
//   empty_i, first_i, last_i ring state, sampled together with start_i
//   mem_*                   single-port memory master (req/gnt, rvalid/rdata)
//   rec_valid_o/ready_i     record stream handshake
//   rec_data_o, rec_idx_o   record payload (field f at [f*DataWidth +: DataWidth])
//   busy_o, done_o          activity flag, one-cycle end-of-drain pulse
//   drained_o               records handed off in the last drain
module trace_drain #(
  parameter int unsigned NumFields = 5,
  parameter int unsigned IdxWidth  = 11,
  parameter int unsigned AddrWidth = 14,
  parameter int unsigned DataWidth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic                           empty_i,
  input  logic [IdxWidth-1:0]            first_i,
  input  logic [IdxWidth-1:0]            last_i,
  output logic                           mem_req_o,
  input  logic                           mem_gnt_i,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic                           mem_we_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  input  logic                           mem_rvalid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic                           rec_valid_o,
  input  logic                           rec_ready_i,
  output logic [NumFields*DataWidth-1:0] rec_data_o,
  output logic [IdxWidth-1:0]            rec_idx_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [IdxWidth:0]              drained_o
);

  localparam int unsigned FieldWidth = (NumFields > 1) ? $clog2(NumFields) : 1;
  localparam int unsigned CntWidth   = IdxWidth + 1;
  localparam logic [FieldWidth-1:0] LastField = FieldWidth'(NumFields - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitR,
    StClr,
    StClrW,
    StOut,
    StFin
  } state_e;

  state_e                               state_q, state_d;
  logic [FieldWidth-1:0]                field_q, field_d;
  logic [IdxWidth-1:0]                  idx_q, idx_d;
  logic [IdxWidth-1:0]                  end_q, end_d;
  logic [CntWidth-1:0]                  count_q, count_d;
  logic [CntWidth-1:0]                  drained_q, drained_d;
  logic                                 abort_q, abort_d;
  logic [NumFields-1:0][DataWidth-1:0]  rec_q, rec_d;

  logic abort_eff;
  logic advance;

  // Abort requests seen while a read is in flight are remembered until it is safe.
  assign abort_eff = abort_i | abort_q;

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    idx_d       = idx_q;
    end_d       = end_q;
    count_d     = count_q;
    drained_d   = drained_q;
    abort_d     = abort_q;
    rec_d       = rec_q;
    advance     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    rec_valid_o = 1'b0;
    done_o      = 1'b0;

    if (state_q != StIdle && abort_i) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d = '0;
          abort_d = 1'b0;
          if (empty_i) begin
            state_d = StFin;
          end else begin
            idx_d   = first_i;
            end_d   = last_i;
            field_d = '0;
            state_d = StReq;
          end
        end
      end

      StReq: begin
        // Request is withdrawn in the abort cycle, so no grant can be taken.
        if (abort_eff) begin
          state_d = StFin;
        end else begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) begin
            state_d = StWaitR;
          end
        end
      end

      StWaitR: begin
        if (mem_rvalid_i) begin
          rec_d[field_q] = mem_rdata_i;
`ifdef TRACE_DRAIN_CLEAR_EN
          state_d = StClr;
`else
          advance = 1'b1;
`endif
        end
      end

`ifdef TRACE_DRAIN_CLEAR_EN
      StClr: begin
        // Clear write to the address just read; abort waits until it completes.
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) begin
          state_d = StClrW;
        end
      end

      StClrW: begin
        if (mem_rvalid_i) begin
          advance = 1'b1;
        end
      end
`endif

      StOut: begin
        if (abort_eff) begin
          state_d = StFin;
        end else begin
          rec_valid_o = 1'b1;
          if (rec_ready_i) begin
            count_d = count_q + CntWidth'(1);
            if (idx_q == end_q) begin
              state_d = StFin;
            end else begin
              idx_d   = idx_q + IdxWidth'(1);
              field_d = '0;
              state_d = StReq;
            end
          end
        end
      end

      StFin: begin
        done_o    = 1'b1;
        drained_d = count_q;
        abort_d   = 1'b0;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Common step after the last response of a field word has been consumed.
    if (advance) begin
      if (abort_eff) begin
        state_d = StFin;
      end else if (field_q == LastField) begin
        state_d = StOut;
      end else begin
        field_d = field_q + FieldWidth'(1);
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      field_q   <= '0;
      idx_q     <= '0;
      end_q     <= '0;
      count_q   <= '0;
      drained_q <= '0;
      abort_q   <= 1'b0;
      rec_q     <= '0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      idx_q     <= idx_d;
      end_q     <= end_d;
      count_q   <= count_d;
      drained_q <= drained_d;
      abort_q   <= abort_d;
      rec_q     <= rec_d;
    end
  end

  assign mem_addr_o  = (AddrWidth'(field_q) << IdxWidth) | AddrWidth'(idx_q);
  assign mem_wdata_o = '0;
  assign rec_data_o  = rec_q;
  assign rec_idx_o   = idx_q;
  assign busy_o      = (state_q != StIdle);
  assign drained_o   = drained_q;

endmodule

// File: tb/tb_trace_drain.sv
// Self-checking bench for trace_drain. A memory responder with random grant and
// read latency serves a bench-owned memory image; each drain is compared with a
// model that lists the expected records from the ring arithmetic alone.
module tb_trace_drain;

  localparam int NF    = 5;
  localparam int IW    = 11;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << IW;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i, abort_i, empty_i;
  logic [IW-1:0]     first_i, last_i;
  logic              mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o, mem_rdata_i;
  logic              rec_valid_o, rec_ready_i;
  logic [NF*DW-1:0]  rec_data_o;
  logic [IW-1:0]     rec_idx_o;
  logic              busy_o, done_o;
  logic [IW:0]       drained_o;

  trace_drain dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .empty_i     (empty_i),
    .first_i     (first_i),
    .last_i      (last_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .rec_valid_o (rec_valid_o),
    .rec_ready_i (rec_ready_i),
    .rec_data_o  (rec_data_o),
    .rec_idx_o   (rec_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .drained_o   (drained_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus knobs (written by the test sequence only).
  int gnt_mode, lat_min, lat_max, ready_mode;

  // Responder-owned state.
  logic [DW-1:0]    mem  [DEPTH*8];
  logic [DW-1:0]    snap [DEPTH*8];
  int               pend;
  logic [DW-1:0]    pend_data;
  int               lat;
  int               n_rd = 0, n_wr = 0, n_done = 0, n_reqc = 0;
  logic [AW-1:0]    txn_addr[$];
  bit               txn_we[$];
  logic [IW-1:0]    obs_idx[$];
  logic [NF*DW-1:0] obs_data[$];

  // Model output.
  logic [IW-1:0]    exp_idx[$];
  logic [NF*DW-1:0] exp_data[$];

  always @(posedge clk) begin
    if (rst_i) begin
      mem_gnt_i    <= 1'b0;
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= '0;
      rec_ready_i  <= 1'b0;
      pend = 0;
      for (int a = 0; a < DEPTH * 8; a++) begin
        mem[a]  = $urandom;
        snap[a] = mem[a];
      end
    end else begin
      if (mem_rvalid_i) mem_rvalid_i <= 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid_i <= 1'b1;
          mem_rdata_i  <= pend_data;
        end
      end
      if (mem_req_o) n_reqc++;
      if (mem_req_o && mem_gnt_i) begin
        txn_addr.push_back(mem_addr_o);
        txn_we.push_back(mem_we_o);
        if (mem_we_o) begin
          mem[mem_addr_o] = mem_wdata_o;
          pend_data = $urandom;  // write response payload must be ignored
          n_wr++;
        end else begin
          pend_data = mem[mem_addr_o];
          n_rd++;
        end
        lat = $urandom_range(lat_max, lat_min);
        if (lat == 0) begin
          mem_rvalid_i <= 1'b1;
          mem_rdata_i  <= pend_data;
        end else begin
          pend = lat;
        end
      end
      mem_gnt_i <= (gnt_mode != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
      case (ready_mode)
        0:       rec_ready_i <= 1'b1;
        1:       rec_ready_i <= 1'($urandom_range(1, 0));
        default: rec_ready_i <= 1'b0;
      endcase
      if (rec_valid_o && rec_ready_i) begin
        obs_idx.push_back(rec_idx_o);
        obs_data.push_back(rec_data_o);
      end
      if (done_o) n_done++;
    end
  end

  // Expected records of a drain over [first, last] from the pre-drain image.
  task automatic build_model(input int first, input int last);
    int n;
    logic [NF*DW-1:0] d;
    int idx;
    exp_idx.delete();
    exp_data.delete();
    n = ((last - first) % DEPTH + DEPTH) % DEPTH + 1;
    for (int k = 0; k < n; k++) begin
      idx = (first + k) % DEPTH;
      for (int f = 0; f < NF; f++) d[f*DW +: DW] = snap[f * DEPTH + idx];
      exp_idx.push_back(IW'(idx));
      exp_data.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic do_start(input int first, input int last, input bit empty);
    @(negedge clk);
    first_i = IW'(first);
    last_i  = IW'(last);
    empty_i = empty;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit timed_out);
    int c;
    c = 0;
    while (n_done == base && c < 4000) begin
      @(negedge clk);
      c++;
    end
    timed_out = (n_done == base);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req_o); end
    n_cmp++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we_o); end
    n_cmp++; if (mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_addr_o); end
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rec_valid_o); end
    n_cmp++; if (rec_data_o !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", rec_data_o); end
    n_cmp++; if (rec_idx_o !== '0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", rec_idx_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (drained_o !== '0) begin n_fail++; $display("FAIL reset_drained got %0d want 0", drained_o); end
  endtask

  task automatic test_basic();
    int bo, bd, bt, bw;
    bit to, found;
    do_reset();
    gnt_mode = 0; lat_min = 0; lat_max = 0; ready_mode = 0;
    bo = obs_idx.size(); bd = n_done; bt = txn_addr.size(); bw = n_wr;
    build_model(3, 5);
    do_start(3, 5, 0);
    wait_done(bd, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (obs_idx.size() - bo !== 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", obs_idx.size() - bo); end
    for (int k = 0; k < exp_idx.size() && bo + k < obs_idx.size(); k++) begin
      n_cmp++; if (obs_idx[bo+k] !== exp_idx[k]) begin n_fail++; $display("FAIL basic_idx[%0d] got %0d want %0d", k, obs_idx[bo+k], exp_idx[k]); end
      n_cmp++; if (obs_data[bo+k] !== exp_data[k]) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", k, obs_data[bo+k], exp_data[k]); end
    end
    found = 1'b0;
    for (int k = bt; k < txn_addr.size(); k++) if (txn_addr[k] == 14'd4100 && !txn_we[k]) found = 1'b1;
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL basic_addr4100 got missing want read"); end
    if (obs_idx.size() - bo >= 2) begin
      n_cmp++; if (obs_data[bo+1][2*DW +: DW] !== snap[4100]) begin n_fail++; $display("FAIL basic_rec4_f2 got %h want %h", obs_data[bo+1][2*DW +: DW], snap[4100]); end
    end
    n_cmp++; if (drained_o !== 12'd3) begin n_fail++; $display("FAIL basic_drained got %0d want 3", drained_o); end
    n_cmp++; if (n_done - bd !== 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", n_done - bd); end
`ifndef TRACE_DRAIN_CLEAR_EN
    n_cmp++; if (n_wr - bw !== 0) begin n_fail++; $display("FAIL basic_writes got %0d want 0", n_wr - bw); end
`endif
  endtask

  task automatic test_wrap();
    int bo, bd;
    bit to;
    do_reset();
    gnt_mode = 1; lat_min = 0; lat_max = 3; ready_mode = 1;
    bo = obs_idx.size(); bd = n_done;
    build_model(2046, 1);
    do_start(2046, 1, 0);
    wait_done(bd, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL wrap_timeout got no done want done"); end
    n_cmp++; if (obs_idx.size() - bo !== 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", obs_idx.size() - bo); end
    for (int k = 0; k < exp_idx.size() && bo + k < obs_idx.size(); k++) begin
      n_cmp++; if (obs_idx[bo+k] !== exp_idx[k]) begin n_fail++; $display("FAIL wrap_idx[%0d] got %0d want %0d", k, obs_idx[bo+k], exp_idx[k]); end
      n_cmp++; if (obs_data[bo+k] !== exp_data[k]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", k, obs_data[bo+k], exp_data[k]); end
    end
    n_cmp++; if (drained_o !== 12'd4) begin n_fail++; $display("FAIL wrap_drained got %0d want 4", drained_o); end
  endtask

  // Runs without reset so drained_o must fall from the previous drain's count to 0.
  task automatic test_empty();
    int br, bq, bd;
    br = n_rd; bq = n_reqc; bd = n_done;
    do_start(9, 20, 1);
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL empty_done got %b want 1", done_o); end
    @(negedge clk);
    n_cmp++; if (drained_o !== '0) begin n_fail++; $display("FAIL empty_drained got %0d want 0", drained_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL empty_busy got %b want 0", busy_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_reqc - bq !== 0) begin n_fail++; $display("FAIL empty_req got %0d want 0", n_reqc - bq); end
    n_cmp++; if (n_done - bd !== 1) begin n_fail++; $display("FAIL empty_done_pulses got %0d want 1", n_done - bd); end
  endtask

  task automatic test_stall();
    int bo, bd, bq, c;
    bit to;
    logic [NF*DW-1:0] hd;
    logic [IW-1:0] hi;
    do_reset();
    gnt_mode = 0; lat_min = 0; lat_max = 2; ready_mode = 2;
    bo = obs_idx.size(); bd = n_done;
    build_model(50, 52);
    do_start(50, 52, 0);
    c = 0;
    while (rec_valid_o !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    n_cmp++; if (rec_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid_timeout got %b want 1", rec_valid_o); end
    hd = rec_data_o; hi = rec_idx_o; bq = n_reqc;
    n_cmp++; if (hd !== exp_data[0]) begin n_fail++; $display("FAIL stall_first_data got %h want %h", hd, exp_data[0]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (rec_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", k, rec_valid_o); end
      n_cmp++; if (rec_data_o !== hd || rec_idx_o !== hi) begin n_fail++; $display("FAIL stall_hold[%0d] got %0d/%h want %0d/%h", k, rec_idx_o, rec_data_o, hi, hd); end
    end
    n_cmp++; if (n_reqc - bq !== 0) begin n_fail++; $display("FAIL stall_req got %0d want 0", n_reqc - bq); end
    ready_mode = 0;
    wait_done(bd, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL stall_timeout got no done want done"); end
    n_cmp++; if (obs_idx.size() - bo !== 3) begin n_fail++; $display("FAIL stall_count got %0d want 3", obs_idx.size() - bo); end
    for (int k = 0; k < exp_idx.size() && bo + k < obs_idx.size(); k++) begin
      n_cmp++; if (obs_idx[bo+k] !== exp_idx[k] || obs_data[bo+k] !== exp_data[k]) begin n_fail++; $display("FAIL stall_rec[%0d] got %0d/%h want %0d/%h", k, obs_idx[bo+k], obs_data[bo+k], exp_idx[k], exp_data[k]); end
    end
    n_cmp++; if (drained_o !== 12'd3) begin n_fail++; $display("FAIL stall_drained got %0d want 3", drained_o); end
  endtask

  task automatic test_abort_wait();
    int br, bd, bo, c, rd_at_abort;
    bit to;
    do_reset();
    gnt_mode = 0; lat_min = 2; lat_max = 2; ready_mode = 0;
    br = n_rd; bd = n_done; bo = obs_idx.size();
    do_start(10, 20, 0);
    c = 0;
    // Seventh read granted = field 1 of the second record, now waiting for rvalid.
    while (n_rd - br < NF + 2 && c < 400) begin @(negedge clk); c++; end
    n_cmp++; if (n_rd - br !== NF + 2) begin n_fail++; $display("FAIL abortw_reach got %0d want %0d", n_rd - br, NF + 2); end
    rd_at_abort = n_rd - br;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_done(bd, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL abortw_timeout got no done want done"); end
    repeat (4) @(negedge clk);
    n_cmp++; if (n_rd - br !== rd_at_abort) begin n_fail++; $display("FAIL abortw_reads got %0d want %0d", n_rd - br, rd_at_abort); end
    n_cmp++; if (drained_o !== 12'd1) begin n_fail++; $display("FAIL abortw_drained got %0d want 1", drained_o); end
    n_cmp++; if (n_done - bd !== 1) begin n_fail++; $display("FAIL abortw_done_pulses got %0d want 1", n_done - bd); end
    n_cmp++; if (obs_idx.size() - bo !== 1) begin n_fail++; $display("FAIL abortw_recs got %0d want 1", obs_idx.size() - bo); end
    n_cmp++; if (busy_o !== 1'b0 || mem_rvalid_i !== 1'b0) begin n_fail++; $display("FAIL abortw_idle got busy %b rvalid %b want 0 0", busy_o, mem_rvalid_i); end
  endtask

  task automatic test_abort_out();
    int bd, bo, c;
    bit to;
    do_reset();
    gnt_mode = 1; lat_min = 0; lat_max = 2; ready_mode = 2;
    bd = n_done; bo = obs_idx.size();
    do_start(100, 104, 0);
    c = 0;
    while (rec_valid_o !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    abort_i = 1'b1;
    #1;
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL aborto_valid_drop got %b want 0", rec_valid_o); end
    @(negedge clk);
    abort_i = 1'b0;
    wait_done(bd, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL aborto_timeout got no done want done"); end
    n_cmp++; if (drained_o !== '0) begin n_fail++; $display("FAIL aborto_drained got %0d want 0", drained_o); end
    n_cmp++; if (obs_idx.size() - bo !== 0) begin n_fail++; $display("FAIL aborto_recs got %0d want 0", obs_idx.size() - bo); end
  endtask

  // Random drains issued back to back, with a start pulse injected mid-drain.
  task automatic test_back_to_back();
    int first, span, bo, bd, r;
    bit to;
    do_reset();
    gnt_mode = 1; lat_min = 0; lat_max = 3; ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      first = $urandom_range(DEPTH - 1, 0);
      span  = $urandom_range(5, 0);
      if (it == 0) first = DEPTH - 2;
      bo = obs_idx.size(); bd = n_done;
      build_model(first, (first + span) % DEPTH);
      do_start(first, (first + span) % DEPTH, 0);
      r = $urandom_range(15, 2);
      repeat (r) @(negedge clk);
      if (busy_o && n_done == bd) begin
        first_i = IW'(first + 700);
        last_i  = IW'(first + 900);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
      wait_done(bd, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL b2b[%0d]_timeout got no done want done", it); end
      n_cmp++; if (obs_idx.size() - bo !== span + 1) begin n_fail++; $display("FAIL b2b[%0d]_count got %0d want %0d", it, obs_idx.size() - bo, span + 1); end
      for (int k = 0; k < exp_idx.size() && bo + k < obs_idx.size(); k++) begin
        n_cmp++; if (obs_idx[bo+k] !== exp_idx[k] || obs_data[bo+k] !== exp_data[k]) begin n_fail++; $display("FAIL b2b[%0d]_rec[%0d] got %0d/%h want %0d/%h", it, k, obs_idx[bo+k], obs_data[bo+k], exp_idx[k], exp_data[k]); end
      end
      n_cmp++; if (drained_o !== 12'(span + 1)) begin n_fail++; $display("FAIL b2b[%0d]_drained got %0d want %0d", it, drained_o, span + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int bd;
    do_reset();
    gnt_mode = 1; lat_min = 0; lat_max = 3; ready_mode = 1;
    bd = n_done;
    do_start(200, 220, 0);
    repeat (25) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got busy %b req %b valid %b want 0 0 0", busy_o, mem_req_o, rec_valid_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - bd !== 0) begin n_fail++; $display("FAIL rstmid_done got %0d want 0", n_done - bd); end
    n_cmp++; if (drained_o !== '0) begin n_fail++; $display("FAIL rstmid_drained got %0d want 0", drained_o); end
  endtask

`ifdef TRACE_DRAIN_CLEAR_EN
  task automatic test_clear();
    int bt, bo, bd;
    bit to;
    logic [AW-1:0] a;
    do_reset();
    gnt_mode = 1; lat_min = 0; lat_max = 2; ready_mode = 0;
    bt = txn_addr.size(); bo = obs_idx.size(); bd = n_done;
    build_model(7, 7);
    do_start(7, 7, 0);
    wait_done(bd, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL clear_timeout got no done want done"); end
    n_cmp++; if (txn_addr.size() - bt !== 2 * NF) begin n_fail++; $display("FAIL clear_txns got %0d want %0d", txn_addr.size() - bt, 2 * NF); end
    for (int f = 0; f < NF && bt + 2 * f + 1 < txn_addr.size(); f++) begin
      a = AW'(f * DEPTH + 7);
      n_cmp++; if (txn_we[bt+2*f] !== 1'b0 || txn_addr[bt+2*f] !== a) begin n_fail++; $display("FAIL clear_read[%0d] got we %b addr %0d want 0 %0d", f, txn_we[bt+2*f], txn_addr[bt+2*f], a); end
      n_cmp++; if (txn_we[bt+2*f+1] !== 1'b1 || txn_addr[bt+2*f+1] !== a) begin n_fail++; $display("FAIL clear_write[%0d] got we %b addr %0d want 1 %0d", f, txn_we[bt+2*f+1], txn_addr[bt+2*f+1], a); end
    end
    if (obs_idx.size() > bo) begin
      n_cmp++; if (obs_data[bo] !== exp_data[0]) begin n_fail++; $display("FAIL clear_rec got %h want %h", obs_data[bo], exp_data[0]); end
    end
    bo = obs_idx.size(); bd = n_done;
    do_start(7, 7, 0);
    wait_done(bd, to);
    n_cmp++; if (obs_idx.size() - bo !== 1) begin n_fail++; $display("FAIL clear_reread_count got %0d want 1", obs_idx.size() - bo); end
    if (obs_idx.size() > bo) begin
      n_cmp++; if (obs_data[bo] !== '0) begin n_fail++; $display("FAIL clear_reread got %h want 0", obs_data[bo]); end
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; empty_i = 1'b0;
    first_i = '0; last_i = '0;
    gnt_mode = 0; lat_min = 0; lat_max = 0; ready_mode = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_empty();
    test_stall();
    test_abort_wait();
    test_abort_out();
    test_back_to_back();
    test_reset_mid();
`ifdef TRACE_DRAIN_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
